// File: rtl/sni_pkg.sv
// sni_pkg: shared types for the SNI SDRAM arbiter.
//   arb_state_t : arbiter FSM states (IDLE / ISSUE / WAIT)
//   op_t        : latched operation of a request (OP_RD / OP_WR)
//   PORT_A/B    : port-select encoding for the round-robin pointer
package sni_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sni_arb_port.sv
// sni_arb_port: per-requester front end of the SDRAM arbiter.
// Captures one pulse-style request at a time, holds it pending until the
// arbiter reports completion, and keeps the last read byte.
//   clk, reset         : clock, synchronous active-high reset
//   addr, wdata        : request address / write data, sampled with the pulse
//   rd_req, wr_req     : 1-cycle request pulses (write wins if both)
//   done               : completion of this port's access (ack while granted)
//   mem_q              : SDRAM read data, taken on done for reads
//   pending            : a captured request awaits service
//   op, req_addr,
//   req_wdata          : latched request presented to the arbiter
//   q                  : last read data, held until the next read completes
//   ready              : port idle / last request complete
module sni_arb_port
  import sni_pkg::*;
#(
  parameter int AW = 25
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic          done,
  input  logic [7:0]    mem_q,
  output logic          pending,
  output op_t           op,
  output logic [AW-1:0] req_addr,
  output logic [7:0]    req_wdata,
  output logic [7:0]    q,
  output logic          ready
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values,
  // independent of the order the statements appear in.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      op        <= OP_RD;
      req_addr  <= '0;
      req_wdata <= '0;
      q         <= '0;
    end else if (done) begin
      pending <= 1'b0;
      if (op == OP_RD) q <= mem_q;
    end else if (!pending && (rd_req || wr_req)) begin
      // Pulses while pending fall through untouched: nothing is queued.
      pending   <= 1'b1;
      op        <= wr_req ? OP_WR : OP_RD;
      req_addr  <= addr;
      req_wdata <= wdata;
    end
  end

  // ready mirrors the pending flop: drops the cycle after capture and
  // rises the cycle after the completing ack.
  assign ready = !pending;

endmodule

// File: rtl/sni_sdram_arb.sv
// sni_sdram_arb: shares one byte-wide SDRAM port between the core memory
// client (port A) and the SNI debug/UART engine (port B).
//   clk, reset                    : clock, synchronous active-high reset
//   a_addr/a_wdata/a_rd_req/
//   a_wr_req, a_q, a_ready        : port A request pulses, read data, ready
//   b_*                           : same for port B (SNI)
//   mem_addr, mem_data            : SDRAM address / write data (held ISSUE..WAIT)
//   mem_rd, mem_wr                : 1-cycle SDRAM strobes
//   mem_q, mem_ack                : SDRAM read data and completion pulse
//   grant_b                       : port B owns the in-flight access
module sni_sdram_arb
  import sni_pkg::*;
#(
  parameter int AW         = 25,
  parameter bit FIXED_PRIO = 1'b1,
  parameter int MAX_WAIT   = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  input  logic          a_rd_req,
  input  logic          a_wr_req,
  output logic [7:0]    a_q,
  output logic          a_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  input  logic          b_rd_req,
  input  logic          b_wr_req,
  output logic [7:0]    b_q,
  output logic          b_ready,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [7:0]    mem_q,
  input  logic          mem_ack,
  output logic          grant_b
);

  localparam int            CW         = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  arb_state_t    state;
  logic          rr_last;
  logic [CW-1:0] wait_cnt;

  logic          a_pending, b_pending;
  op_t           a_op, b_op, win_op;
  logic [AW-1:0] a_req_addr, b_req_addr, win_addr;
  logic [7:0]    a_req_wdata, b_req_wdata, win_wdata;
  logic          a_done, b_done, pick_b;

  // Only an ack seen in WAIT completes anything; late acks are dropped.
  assign a_done = (state == WAIT) && mem_ack && !grant_b;
  assign b_done = (state == WAIT) && mem_ack &&  grant_b;

  sni_arb_port #(.AW(AW)) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .addr     (a_addr),
    .wdata    (a_wdata),
    .rd_req   (a_rd_req),
    .wr_req   (a_wr_req),
    .done     (a_done),
    .mem_q    (mem_q),
    .pending  (a_pending),
    .op       (a_op),
    .req_addr (a_req_addr),
    .req_wdata(a_req_wdata),
    .q        (a_q),
    .ready    (a_ready)
  );

  sni_arb_port #(.AW(AW)) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .addr     (b_addr),
    .wdata    (b_wdata),
    .rd_req   (b_rd_req),
    .wr_req   (b_wr_req),
    .done     (b_done),
    .mem_q    (mem_q),
    .pending  (b_pending),
    .op       (b_op),
    .req_addr (b_req_addr),
    .req_wdata(b_req_wdata),
    .q        (b_q),
    .ready    (b_ready)
  );

  // Winner selection, meaningful only in IDLE with something pending.
  // rr_last records the port served last; round-robin favours the other.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    pick_b = 1'b0;
    if (b_pending) begin
      if (!a_pending)      pick_b = 1'b1;
      else if (FIXED_PRIO) pick_b = (wait_cnt >= WAIT_LIMIT);
      else                 pick_b = (rr_last == PORT_A);
    end
    win_op    = pick_b ? b_op        : a_op;
    win_addr  = pick_b ? b_req_addr  : a_req_addr;
    win_wdata = pick_b ? b_req_wdata : a_req_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      grant_b  <= 1'b0;
      rr_last  <= PORT_A;
    end else begin
      case (state)
        IDLE: begin
          if (a_pending || b_pending) begin
            // Strobe is registered here so it is high exactly in ISSUE.
            grant_b  <= pick_b;
            rr_last  <= pick_b ? PORT_B : PORT_A;
            mem_addr <= win_addr;
            mem_data <= win_wdata;
            mem_rd   <= (win_op == OP_RD);
            mem_wr   <= (win_op == OP_WR);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (mem_ack) begin
            grant_b <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: cycles B has waited without being granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!b_pending || grant_b || (state == IDLE && pick_b)) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: doc/sni_sdram_arb.md
Name: sni_sdram_arb

Overview:
- Two-requester arbiter that shares the single byte-wide SDRAM port between the core-side memory client (port A) and the SNI debug/UART engine (port B).
- Latches pulse-style read/write requests from each side and serialises them onto the SDRAM port. Returns read data and a per-port ready level.
- Selects between fixed priority and round-robin. A starvation counter guarantees port B progress under fixed priority.
- Sits between the SNI engine, the core memory mux and the SDRAM controller.

Parameters:
- AW, 25, SDRAM byte address width.
- FIXED_PRIO, 1, 1 = port A wins ties; 0 = round-robin (alternate winner on ties).
- MAX_WAIT, 64, under FIXED_PRIO: cycles port B may stay pending before it is forced to win the next grant; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- a_addr  in  AW  port A address, sampled with request
- a_wdata  in  8  port A write data, sampled with request
- a_rd_req  in  1  port A read request, 1-cycle pulse
- a_wr_req  in  1  port A write request, 1-cycle pulse
- a_q  out  8  port A read data, held until the next A read completes
- a_ready  out  1  high = port A idle / last request complete
- b_addr, b_wdata, b_rd_req, b_wr_req, b_q, b_ready: same as port A, for port B (SNI)
- mem_addr  out  AW  SDRAM address
- mem_data  out  8  SDRAM write data
- mem_rd  out  1  SDRAM read strobe, 1-cycle pulse
- mem_wr  out  1  SDRAM write strobe, 1-cycle pulse
- mem_q  in  8  SDRAM read data, valid with mem_ack
- mem_ack  in  1  SDRAM completion, 1-cycle pulse
- grant_b  out  1  high while port B owns the in-flight access (debug)

Behaviour:
- Reset values: a_ready = b_ready = 1; mem_rd = mem_wr = 0; a_q = b_q = 0; mem_addr = mem_data = 0; grant_b = 0; pending flags clear; wait counter 0; round-robin pointer = A; state IDLE.
- Request capture, per port:
  - A req pulse while ready=1 sets pending and latches addr, wdata and op. ready drops the next cycle.
  - A req pulse while pending is ignored (protocol violation; no state change).
  - rd_req and wr_req in the same cycle: write wins.
- State machine IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: if any port is pending, choose a winner, register mem_addr/mem_data/grant_b, and go to ISSUE.
  - ISSUE: assert mem_rd or mem_wr for exactly one cycle, then go to WAIT.
  - WAIT: on mem_ack, clear the winner's pending flag. For a read, a_q/b_q <= mem_q. Go to IDLE.
- Winner ready rises the cycle after mem_ack; the _q value is valid in that same cycle.
- Minimum latency: request pulse at cycle N, strobe at N+2, ack at M >= N+3, ready high at M+1.
- Request captured in the same cycle the arbiter is in IDLE with nothing pending: captured at N, arbitrated at N+1.
- Arbitration, evaluated in IDLE:
  - Only one pending: it wins.
  - Both pending, FIXED_PRIO=1: A wins unless wait counter >= MAX_WAIT, then B wins.
  - Both pending, FIXED_PRIO=0: the port not served last wins; the pointer updates at grant.
- Wait counter:
  - Increments each cycle B is pending and not granted; saturates at MAX_WAIT.
  - Clears when B is granted or B is not pending.
- A new request on the non-granted port during WAIT is captured normally. It is served on the next IDLE cycle, giving back-to-back accesses with one IDLE cycle between.
- mem_addr, mem_data and grant_b hold stable from ISSUE until the end of WAIT.
- Reset mid-transaction:
  - All pending flags clear and the state returns to IDLE.
  - A late mem_ack arriving in IDLE is ignored; no _q update and no ready change.
- mem_ack outside WAIT is always ignored.

Decomposition:
- Package sni_pkg holds:
  - arb state enum (IDLE/ISSUE/WAIT);
  - op typedef (OP_RD/OP_WR);
  - the port-select constants PORT_A and PORT_B.
- Natural sub-module: sni_arb_port, instantiated twice. It holds the request capture latch, pending flag, ready and the q register.

Test Plan:
- Single read on port B at 0x0001234, mem_ack 3 cycles after mem_rd, mem_q=0x5A:
  - mem_rd pulses once with mem_addr=0x0001234;
  - b_q=0x5A and b_ready=1 the cycle after mem_ack;
  - a_ready stays 1 throughout.
- Simultaneous A write (0x10, 0xAA) and B read (0x20), FIXED_PRIO=1:
  - mem_wr with addr 0x10 and data 0xAA is issued first;
  - mem_rd for 0x20 follows after A's ack, with grant_b=1.
- FIXED_PRIO=1, MAX_WAIT=4, A re-requests immediately after every ack while B stays pending:
  - B is granted no later than the first IDLE after its wait count reaches 4;
  - the counter then clears.
- FIXED_PRIO=0, both ports continuously re-requesting: grants alternate A, B, A, B over 8 accesses.
- Port A: rd and wr pulse in the same cycle, then a second rd pulse while pending:
  - a single mem_wr is issued;
  - the second pulse produces no extra access.
- Reset asserted during WAIT, then mem_ack arrives:
  - both ready = 1 and no strobes;
  - the _q registers stay 0;
  - the next request proceeds normally.
